// File: rtl/p1_p2_rr_arbiter.sv
// p1_p2_rr_arbiter: two-requester round-robin arbiter.
// - Mutually exclusive, registered grants g1/g2.
// - A fixed idle gap (GAP_CYC cycles) follows every release.
// - z pulses for one cycle at the start of every new grant.
// Optional feature macro: ARB_TIMEOUT_EN
// - When defined, a grant is forcibly ended after MAX_HOLD cycles, but only if the other requester is waiting.
//
// Handshake: P1/P2 are level requests, held high while ownership is wanted.
// - A request sampled at edge N shows its grant after edge N.
// - Dropping the request releases the grant at the next edge.
// Debug outputs o_state and o_hold_at_limit expose the FSM for checkers.
module p1_p2_rr_arbiter #(
  parameter int GAP_CYC  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       P1,
  input  logic       P2,
  output logic       g1,
  output logic       g2,
  output logic       busy,
  output logic       z,
  output logic [1:0] o_state,
  output logic       o_hold_at_limit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT1 = 2'd1,
    S_GNT2 = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;        // 0: P1 owned last, 1: P2 owned last
  logic       w_last_nxt;
  logic [3:0] r_gap_cnt;
  logic [3:0] w_gap_nxt;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_nxt;
  logic       r_z;
  logic       w_z_nxt;
  logic       w_hold_at_max;
  logic       w_timeout;
  logic [7:0] w_hold_inc;

  assign w_hold_at_max = (r_hold_cnt == HOLD_LAST);
  assign w_hold_inc    = (r_hold_cnt == 8'hFF) ? 8'hFF : r_hold_cnt + 8'd1;

`ifdef ARB_TIMEOUT_EN
  assign w_timeout = w_hold_at_max;
`else
  assign w_timeout = 1'b0;
`endif

  // State, owner history, counters and the grant-start pulse register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_gap_cnt  <= 4'd0;
      r_hold_cnt <= 8'd0;
      r_z        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_z        <= w_z_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hold/release in GNTx, count down the gap
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_z_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (P1 && P2) begin
          // Tie goes to whoever did not own last
          w_state_nxt = r_last ? S_GNT1 : S_GNT2;
          w_last_nxt  = ~r_last;
        end else if (P1) begin
          w_state_nxt = S_GNT1;
          w_last_nxt  = 1'b0;
        end else if (P2) begin
          w_state_nxt = S_GNT2;
          w_last_nxt  = 1'b1;
        end
        if (P1 || P2) begin
          w_hold_nxt = 8'd0;
          w_z_nxt    = 1'b1;
        end
      end
      S_GNT1: begin
        if (!P1 || (w_timeout && P2)) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = 4'd0;
        end else begin
          w_hold_nxt = w_hold_inc;
        end
      end
      S_GNT2: begin
        if (!P2 || (w_timeout && P1)) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = 4'd0;
        end else begin
          w_hold_nxt = w_hold_inc;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = 4'd0;
        end else begin
          w_gap_nxt = r_gap_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign g1              = (r_state == S_GNT1);
  assign g2              = (r_state == S_GNT2);
  assign busy            = g1 | g2;
  assign z               = r_z;
  assign o_state         = r_state;
  assign o_hold_at_limit = w_hold_at_max & busy;

endmodule

// File: tb/tb_p1_p2_rr_arbiter.sv
// tb_p1_p2_rr_arbiter: bench for p1_p2_rr_arbiter.
// A behavioural model pushes expected {g1,g2,z,busy} after each edge.
// The DUT outputs are popped and compared 1 ns after that edge.
// Compile with +define+ARB_TIMEOUT_EN to exercise the forced release.
module tb_p1_p2_rr_arbiter;

  localparam int GAP_CYC  = 2;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       P1 = 1'b0;
  logic       P2 = 1'b0;
  logic       g1, g2, busy, z;
  logic [1:0] o_state;
  logic       o_hold_at_limit;

  p1_p2_rr_arbiter #(.GAP_CYC(GAP_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk             (clk),
    .reset           (reset),
    .P1              (P1),
    .P2              (P2),
    .g1              (g1),
    .g2              (g2),
    .busy            (busy),
    .z               (z),
    .o_state         (o_state),
    .o_hold_at_limit (o_hold_at_limit)
  );

  // Clock: 10 ns period
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  // Reference model state: owner 0=none, 1=P1, 2=P2
  int   m_owner    = 0;
  int   m_gap_left = 0;
  int   m_last     = 2;
  int   m_hold     = 0;
  logic prev_z     = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, given the inputs sampled at that edge
  task automatic model_edge(input logic p1, input logic p2, input logic rst_n);
    logic mine, other, mz;
    mz = 1'b0;
    if (!rst_n) begin
      m_owner = 0; m_gap_left = 0; m_last = 2; m_hold = 0;
    end else if (m_owner != 0) begin
      mine  = (m_owner == 1) ? p1 : p2;
      other = (m_owner == 1) ? p2 : p1;
      if (!mine || (TIMEOUT && (m_hold == MAX_HOLD - 1) && other)) begin
        m_owner = 0;
        m_gap_left = GAP_CYC;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      if (p1 && p2)  m_owner = (m_last == 1) ? 2 : 1;
      else if (p1)   m_owner = 1;
      else if (p2)   m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner; m_hold = 0; mz = 1'b1;
      end
    end
    exp_q.push_back({m_owner == 1, m_owner == 2, mz, m_owner != 0});
  endtask

  // Driver: apply inputs, take one edge, then compare against the scoreboard
  task automatic step(input logic p1, input logic p2, input logic rst_n);
    logic [3:0] e;
    reset = rst_n; P1 = p1; P2 = p2;
    @(posedge clk);
    model_edge(p1, p2, rst_n);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check("g1", {7'd0, g1}, {7'd0, e[3]});
      check("g2", {7'd0, g2}, {7'd0, e[2]});
      check("z", {7'd0, z}, {7'd0, e[1]});
      check("busy", {7'd0, busy}, {7'd0, e[0]});
    end
    check("excl", {7'd0, g1 & g2}, 8'd0);
    check("z_twice", {7'd0, z & prev_z}, 8'd0);
    check("z_no_busy", {7'd0, z & ~busy}, 8'd0);
    prev_z = z;
  endtask

  initial begin : main
    int owner, low_cnt, n1, n2;
    logic rp1, rp2, rrst;
    bit   seen;

    // 1: reset with both requesting, first grant goes to P1
    step(1'b1, 1'b1, 1'b0);
    check("rst_g1", {7'd0, g1}, 8'd0);
    check("rst_z", {7'd0, z}, 8'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("t1_first_g1", {7'd0, g1}, 8'd1);
    check("t1_first_z", {7'd0, z}, 8'd1);
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // 2: single request held 4 cycles
    repeat (4) step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // 3: tie alternation g1, g2, g1 after a reset
    step(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      seen = 1'b0;
      low_cnt = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step(1'b1, 1'b1, 1'b1);
        if (busy) seen = 1'b1; else low_cnt++;
      end
      check("t3_grant_seen", {7'd0, seen}, 8'd1);
      owner = g1 ? 1 : 2;
      check("t3_owner", 8'(owner), (r % 2 == 0) ? 8'd1 : 8'd2);
      // Low cycles = drop edge, GAP_CYC gap cycles; the drop cycle is counted in the previous round
      if (r > 0) check("t3_gap_len", 8'(low_cnt + 1), 8'(GAP_CYC + 1));
      repeat (2) step(1'b1, 1'b1, 1'b1);
      if (owner == 1) step(1'b0, 1'b1, 1'b1);
      else            step(1'b1, 1'b0, 1'b1);
    end
    repeat (4) step(1'b0, 1'b0, 1'b1);

    // 4: reset in the middle of a P2 grant
    step(1'b0, 1'b1, 1'b1);
    check("t4_g2", {7'd0, g2}, 8'd1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("t4_rst_g2", {7'd0, g2}, 8'd0);
    step(1'b1, 1'b1, 1'b1);
    check("t4_after_g1", {7'd0, g1}, 8'd1);
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // 5: both held high for 20 cycles from a fresh reset
    step(1'b0, 1'b0, 1'b0);
    n1 = 0; n2 = 0;
    repeat (20) begin
      step(1'b1, 1'b1, 1'b1);
      if (g1) n1++;
      if (g2) n2++;
    end
    check("t5_g1_cycles", 8'(n1), TIMEOUT ? 8'(MAX_HOLD) : 8'd20);
    check("t5_g2_cycles", 8'(n2), TIMEOUT ? 8'(MAX_HOLD) : 8'd0);
    repeat (4) step(1'b0, 1'b0, 1'b1);

    // 6: random traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      rp1  = ($urandom_range(0, 3) != 0);
      rp2  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 99) != 0);
      step(rp1, rp2, rrst);
    end

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
